// File: rtl/reg_bank_seq_ctrl.sv
// rtl/reg_bank_seq_ctrl.sv - micro-sequencer driving a 16-bit 8-entry register bank
// Ports:
//   clk, reset                  clock and synchronous active-high reset
//   instr_valid/instr_ready     instruction handshake; instr = {op, rd, ra, rb, imm4}
//   rega_select/regb_select     bank read addresses, held from accept through WB
//   reg_a/reg_b                 bank read data
//   write/write_addr/write_data bank write port; write pulses for one cycle in WB
//   done                        one-cycle pulse when an instruction retires
//   result/flag_z/flag_c        last computed result and flags, updated in EX
module reg_bank_seq_ctrl #(
   parameter int DATA_W    = 16,
   parameter int ADDR_W    = 3,
   parameter int READ_WAIT = 1
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              instr_valid,
   output logic              instr_ready,
   input  logic [15:0]       instr,
   output logic [ADDR_W-1:0] rega_select,
   output logic [ADDR_W-1:0] regb_select,
   input  logic [DATA_W-1:0] reg_a,
   input  logic [DATA_W-1:0] reg_b,
   output logic              write,
   output logic [ADDR_W-1:0] write_addr,
   output logic [DATA_W-1:0] write_data,
   output logic              done,
   output logic [DATA_W-1:0] result,
   output logic              flag_z,
   output logic              flag_c
);

   localparam logic [2:0] OP_NOP  = 3'd0;
   localparam logic [2:0] OP_ADD  = 3'd1;
   localparam logic [2:0] OP_SUB  = 3'd2;
   localparam logic [2:0] OP_AND  = 3'd3;
   localparam logic [2:0] OP_OR   = 3'd4;
   localparam logic [2:0] OP_XOR  = 3'd5;
   localparam logic [2:0] OP_MOV  = 3'd6;
   localparam logic [2:0] OP_ADDI = 3'd7;

   localparam logic [2:0] WAIT_LAST = 3'(READ_WAIT - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_RD   = 2'd1,
      S_EX   = 2'd2,
      S_WB   = 2'd3
   } state_t;

   state_t            state;
   state_t            state_nx;
   logic [2:0]        op_q;
   logic [ADDR_W-1:0] rd_q;
   logic [3:0]        imm_q;
   logic [2:0]        wait_cnt;

   logic [DATA_W-1:0] imm_sext;
   logic [DATA_W-1:0] alu_b;
   logic [DATA_W:0]   alu_sum;
   logic [DATA_W-1:0] alu_res;
   logic              alu_c;

   // write_data is the result register itself: it only changes on the
   // EX->WB edge, so it naturally holds its value outside WB.
   assign write_data = result;

   always_ff @(posedge clk) begin
      if (reset) begin
         state <= S_IDLE;
      end else begin
         state <= state_nx;
      end
   end

   always_comb begin
      state_nx    = state;
      instr_ready = 1'b0;
      write       = 1'b0;
      done        = 1'b0;
      case (state)
         S_IDLE: begin
            instr_ready = 1'b1;
            if (instr_valid) begin
               state_nx = S_RD;
            end
         end
         S_RD: begin
            if (wait_cnt == WAIT_LAST) begin
               state_nx = S_EX;
            end
         end
         S_EX: begin
            if (op_q == OP_NOP) begin
               done     = 1'b1;
               state_nx = S_IDLE;
            end else begin
               state_nx = S_WB;
            end
         end
         S_WB: begin
            write    = 1'b1;
            done     = 1'b1;
            state_nx = S_IDLE;
         end
         default: state_nx = S_IDLE;
      endcase
      // Reset aborts the instruction: no handshake, strobe or retire pulse
      // may escape in the reset cycle.
      if (reset) begin
         instr_ready = 1'b0;
         write       = 1'b0;
         done        = 1'b0;
      end
   end

   assign imm_sext = {{(DATA_W-4){imm_q[3]}}, imm_q};
   assign alu_b    = (op_q == OP_ADDI) ? imm_sext : reg_b;
   assign alu_sum  = {1'b0, reg_a} + {1'b0, alu_b};

   always_comb begin
      alu_res = '0;
      alu_c   = 1'b0;
      case (op_q)
         OP_ADD, OP_ADDI: begin
            alu_res = alu_sum[DATA_W-1:0];
            alu_c   = alu_sum[DATA_W];
         end
         OP_SUB: begin
            alu_res = reg_a - reg_b;
            alu_c   = (reg_a < reg_b);
         end
         OP_AND:  alu_res = reg_a & reg_b;
         OP_OR:   alu_res = reg_a | reg_b;
         OP_XOR:  alu_res = reg_a ^ reg_b;
         OP_MOV:  alu_res = reg_a;
         default: alu_res = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         op_q        <= OP_NOP;
         rd_q        <= '0;
         imm_q       <= '0;
         wait_cnt    <= '0;
         rega_select <= '0;
         regb_select <= '0;
         write_addr  <= '0;
         result      <= '0;
         flag_z      <= 1'b0;
         flag_c      <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               wait_cnt <= '0;
               if (instr_valid) begin
                  op_q        <= instr[15:13];
                  rd_q        <= ADDR_W'(instr[12:10]);
                  imm_q       <= instr[3:0];
                  rega_select <= ADDR_W'(instr[9:7]);
                  regb_select <= ADDR_W'(instr[6:4]);
               end
            end
            S_RD: begin
               wait_cnt <= wait_cnt + 3'd1;
            end
            S_EX: begin
               // NOP retires here and leaves result/flags untouched.
               if (op_q != OP_NOP) begin
                  result     <= alu_res;
                  flag_z     <= (alu_res == '0);
                  flag_c     <= alu_c;
                  write_addr <= rd_q;
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_reg_bank_seq_ctrl.sv
// tb/tb_reg_bank_seq_ctrl.sv - scoreboard bench for reg_bank_seq_ctrl
module tb_reg_bank_seq_ctrl;

   localparam int RW = 1;

   logic        clk;
   logic        reset;
   logic        instr_valid;
   logic        instr_ready;
   logic [15:0] instr;
   logic [2:0]  rega_select;
   logic [2:0]  regb_select;
   logic [15:0] reg_a;
   logic [15:0] reg_b;
   logic        write;
   logic [2:0]  write_addr;
   logic [15:0] write_data;
   logic        done;
   logic [15:0] result;
   logic        flag_z;
   logic        flag_c;

   typedef struct {
      logic        nop;
      logic [2:0]  addr;
      logic [15:0] data;
      logic        z;
      logic        c;
      int          cyc;
   } exp_t;

   exp_t        sb[$];
   logic [15:0] bank [8];
   int          cyc;
   int          total;
   int          bad;
   int          acc_cyc;

   reg_bank_seq_ctrl #(.DATA_W(16), .ADDR_W(3), .READ_WAIT(RW)) dut (
      .clk(clk), .reset(reset),
      .instr_valid(instr_valid), .instr_ready(instr_ready), .instr(instr),
      .rega_select(rega_select), .regb_select(regb_select),
      .reg_a(reg_a), .reg_b(reg_b),
      .write(write), .write_addr(write_addr), .write_data(write_data),
      .done(done), .result(result), .flag_z(flag_z), .flag_c(flag_c)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   // Bank model: combinational reads, preloaded whenever reset is high.
   assign reg_a = bank[rega_select];
   assign reg_b = bank[regb_select];
   always @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < 8; i++) bank[i] <= 16'h0000;
         bank[1] <= 16'h0001;
         bank[2] <= 16'h0002;
         bank[5] <= 16'hFFFD;
      end else if (write) begin
         bank[write_addr] <= write_data;
      end
   end

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   function automatic logic [15:0] mk(input int op, input int rd, input int ra, input int rb, input int imm);
      return {op[2:0], rd[2:0], ra[2:0], rb[2:0], imm[3:0]};
   endfunction

   // Monitor: every retire pops one expected entry and checks it.
   always @(negedge clk) begin
      if (write === 1'b1 || done === 1'b1) begin
         if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL unexpected_retire actual=write%0b/done%0b required=none", write, done);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("done",   done,   1'b1);
            chk("write",  write,  !e.nop);
            chk("cycle",  cyc,    e.cyc);
            chk("result", result, e.data);
            chk("flag_z", flag_z, e.z);
            chk("flag_c", flag_c, e.c);
            if (!e.nop) begin
               chk("write_addr", write_addr, e.addr);
               chk("write_data", write_data, e.data);
            end
         end
      end
   end

   // Called at a negedge; returns at the negedge after the accept edge.
   task automatic issue(input logic [15:0] ins, input logic nop, input int addr,
                        input logic [15:0] data, input logic z, input logic c, input logic push);
      exp_t e;
      int   n;
      instr       = ins;
      instr_valid = 1'b1;
      n = 0;
      while (instr_ready !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n == 50) chk("accept_timeout", 32'(n), 32'd0);
      @(posedge clk);
      acc_cyc = cyc;
      e.nop  = nop;
      e.addr = addr[2:0];
      e.data = data;
      e.z    = z;
      e.c    = c;
      e.cyc  = acc_cyc + (nop ? 1 : 2) + RW;
      if (push) sb.push_back(e);
      @(negedge clk);
      instr_valid = 1'b0;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 40) begin
         @(posedge clk);
         n++;
      end
      chk("drain", sb.size(), 0);
      @(negedge clk);
   endtask

   initial begin
      int first_acc;
      total = 0;
      bad = 0;
      cyc = 0;
      reset = 1'b1;
      // reset must win over a simultaneous valid instruction
      instr_valid = 1'b1;
      instr = mk(1, 3, 1, 2, 0);
      @(posedge clk);
      @(posedge clk);
      @(negedge clk);
      chk("rst_instr_ready", instr_ready, 1'b0);
      chk("rst_write",       write,       1'b0);
      chk("rst_done",        done,        1'b0);
      chk("rst_result",      result,      16'h0);
      chk("rst_flags",       {flag_z, flag_c}, 2'b00);
      chk("rst_selects",     {rega_select, regb_select}, 6'h00);
      chk("rst_write_port",  {write_addr, write_data}, 19'h0);
      reset = 1'b0;
      instr_valid = 1'b0;
      @(negedge clk);
      chk("idle_ready", instr_ready, 1'b1);

      // ADD r3 = r1 + r2
      issue(mk(1, 3, 1, 2, 0), 1'b0, 3, 16'h0003, 1'b0, 1'b0, 1'b1);
      chk("sel_a", rega_select, 3'd1);
      chk("sel_b", regb_select, 3'd2);
      drain();
      // SUB r4 = r0 - r1 -> borrow
      issue(mk(2, 4, 0, 1, 0), 1'b0, 4, 16'hFFFF, 1'b0, 1'b1, 1'b1);
      drain();
      // ADDI r6 = r5 + 3 -> wraps to zero with carry
      issue(mk(7, 6, 5, 0, 3), 1'b0, 6, 16'h0000, 1'b1, 1'b1, 1'b1);
      drain();

      // XOR r7 = r3 ^ r4, then AND r2 = r4 & r1 held valid while busy
      issue(mk(5, 7, 3, 4, 0), 1'b0, 7, 16'hFFFC, 1'b0, 1'b0, 1'b1);
      first_acc = acc_cyc;
      instr = mk(3, 2, 4, 1, 0);
      instr_valid = 1'b1;
      for (int i = 0; i < 3; i++) begin
         chk("busy_ready", instr_ready, 1'b0);
         chk("busy_sel_a", rega_select, 3'd3);
         @(negedge clk);
      end
      chk("ready_cycle4", instr_ready, 1'b1);
      issue(mk(3, 2, 4, 1, 0), 1'b0, 2, 16'h0001, 1'b0, 1'b0, 1'b1);
      chk("b2b_accept", acc_cyc - first_acc, 4);
      drain();

      // ADD aborted by reset in EX: nothing may retire
      issue(mk(1, 5, 1, 1, 0), 1'b0, 5, 16'h0002, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      chk("abort_rst_ready", instr_ready, 1'b0);
      reset = 1'b0;
      @(negedge clk);
      chk("abort_ready", instr_ready, 1'b1);
      chk("abort_result", result, 16'h0);
      chk("abort_write", write, 1'b0);

      // SUB r0 = r3 - r3 (bank reloaded, r3=0) -> zero, then NOP keeps it
      issue(mk(2, 0, 3, 3, 0), 1'b0, 0, 16'h0000, 1'b1, 1'b0, 1'b1);
      drain();
      issue(mk(0, 1, 2, 3, 0), 1'b1, 0, 16'h0000, 1'b1, 1'b0, 1'b1);
      drain();
      chk("nop_ready", instr_ready, 1'b1);
      chk("nop_no_write_r1", bank[1], 16'h0001);

      repeat (3) @(negedge clk);
      chk("sb_empty", sb.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog actual=timeout required=finish");
      $fatal(1, "watchdog");
   end

endmodule
